memory_stage: RTL

- Pipeline stage directly downstream of the execute stage; consumes the effective address (valE) and store data (valB) it produces for LOAD/STORE instructions.
- Performs one data-memory transaction per instruction over a valid/ready request channel plus a response channel.
- Applies byte-lane steering, store strobes, load sign/zero extension and alignment checking.
- Returns valM, or a fault flag, to the writeback side through an output valid/ready handshake.

---
 rtl/memory_stage.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/memory_stage.sv
// Data-memory pipeline stage: one load/store transaction per instruction with
// byte-lane steering, store strobes, load extension and alignment faulting.
module memory_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [2:0]        func3,
    input  logic [XLEN-1:0]   valE,
    input  logic [XLEN-1:0]   valB,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   valM,
    output logic              mem_fault,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic [XLEN-1:0]   dmem_addr,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [XLEN/8-1:0] dmem_wstrb,
    input  logic              dmem_rsp_valid,
    input  logic [XLEN-1:0]   dmem_rdata
);

    localparam int unsigned NB = XLEN / 8;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    if (XLEN != 32) begin : g_bad_xlen
        $error("memory_stage supports only XLEN == 32");
    end

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        func3_q, func3_d;
    logic [1:0]        lane_q, lane_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   valm_q, valm_d;
    logic              fault_q, fault_d;
    logic              req_valid_q, req_valid_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic              we_q, we_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [NB-1:0]     wstrb_q, wstrb_d;

    logic              is_load, is_store, legal_f3, aligned;
    logic [NB-1:0]     st_wstrb;
    logic [XLEN-1:0]   st_wdata;
    logic [7:0]        rbyte;
    logic [15:0]       rhalf;
    logic [XLEN-1:0]   ld_data;

    // Decode of the instruction presented by the execute stage
    always_comb begin
        is_load  = (opcode == OP_LOAD);
        is_store = (opcode == OP_STORE);
        legal_f3 = 1'b0;
        if (is_load)
            legal_f3 = (func3 == 3'd0) || (func3 == 3'd1) || (func3 == 3'd2) ||
                       (func3 == 3'd4) || (func3 == 3'd5);
        else if (is_store)
            legal_f3 = (func3 == 3'd0) || (func3 == 3'd1) || (func3 == 3'd2);
        case (func3[1:0])
            2'd1:    aligned = (valE[0] == 1'b0);
            2'd2:    aligned = (valE[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        case (func3[1:0])
            2'd0: begin
                st_wstrb = NB'(4'b0001) << valE[1:0];
                st_wdata = {4{valB[7:0]}};
            end
            2'd1: begin
                st_wstrb = NB'(4'b0011) << valE[1:0];
                st_wdata = {2{valB[15:0]}};
            end
            default: begin
                st_wstrb = NB'(4'b1111);
                st_wdata = valB;
            end
        endcase
    end

    // Lane selection and extension of the returned read word
    always_comb begin
        case (lane_q)
            2'd0:    rbyte = dmem_rdata[7:0];
            2'd1:    rbyte = dmem_rdata[15:8];
            2'd2:    rbyte = dmem_rdata[23:16];
            default: rbyte = dmem_rdata[31:24];
        endcase
        rhalf = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (func3_q)
            3'd0:    ld_data = {{24{rbyte[7]}}, rbyte};
            3'd1:    ld_data = {{16{rhalf[15]}}, rhalf};
            3'd4:    ld_data = {24'd0, rbyte};
            3'd5:    ld_data = {16'd0, rhalf};
            default: ld_data = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        func3_d     = func3_q;
        lane_d      = lane_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        valm_d      = valm_q;
        fault_d     = fault_q;
        req_valid_d = req_valid_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    in_ready_d = 1'b0;
                    func3_d    = func3;
                    lane_d     = valE[1:0];
                    valm_d     = '0;
                    if ((is_load || is_store) && legal_f3 && aligned) begin
                        state_d     = REQ;
                        req_valid_d = 1'b1;
                        addr_d      = {valE[XLEN-1:2], 2'b00};
                        we_d        = is_store;
                        wdata_d     = is_store ? st_wdata : '0;
                        wstrb_d     = is_store ? st_wstrb : '0;
                    end else begin
                        // Non-memory ops complete without faulting; bad accesses fault
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        fault_d     = is_load || is_store;
                    end
                end
            end
            REQ: begin
                if (dmem_req_ready) begin
                    req_valid_d = 1'b0;
                    if (we_q) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        fault_d     = 1'b0;
                    end else begin
                        state_d = WAIT_RSP;
                    end
                end
            end
            WAIT_RSP: begin
                if (dmem_rsp_valid) begin
                    state_d     = DONE;
                    valm_d      = ld_data;
                    fault_d     = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    valm_d      = '0;
                    fault_d     = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            func3_q     <= '0;
            lane_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            valm_q      <= '0;
            fault_q     <= 1'b0;
            req_valid_q <= 1'b0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
        end else begin
            state_q     <= state_d;
            func3_q     <= func3_d;
            lane_q      <= lane_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            valm_q      <= valm_d;
            fault_q     <= fault_d;
            req_valid_q <= req_valid_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign valM           = valm_q;
    assign mem_fault      = fault_q;
    assign dmem_req_valid = req_valid_q;
    assign dmem_addr      = addr_q;
    assign dmem_we        = we_q;
    assign dmem_wdata     = wdata_q;
    assign dmem_wstrb     = wstrb_q;

endmodule
